// File: rtl/ov7670_cfg_sequencer_if.sv
// Command channel between the configuration sequencer and the SCCB write engine.
// A 16-bit {register, value} word is transferred on the cycle where
// cmd_valid and cmd_ready are both high.
interface ov7670_cfg_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 configuration sequencer: walks a per-mode register table, issues
// each {register, value} word over a valid/ready channel, executes embedded
// delay entries and stops on a sentinel word or on table overrun.
module ov7670_cfg_sequencer #(
  parameter int          ADDR_W    = 8,
  parameter int          NUM_MODES = 2,
  parameter int          MODE_W    = 1,
  parameter logic [7:0]  DELAY_REG = 8'hF0,
  parameter logic [15:0] END_WORD  = 16'hFFFF,
  parameter int          WAIT_UNIT = 25000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MODE_W-1:0]      mode,
  ov7670_cfg_sequencer_if.master cmd,
  output logic [ADDR_W-1:0]      index,
  output logic                   busy,
  output logic                   finished,
  output logic                   error
);

  localparam int                CYC_W       = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;
  localparam logic [CYC_W-1:0]  CYC_RELOAD  = CYC_W'(WAIT_UNIT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX    = '1;
  localparam logic [31:0]       NUM_MODES_U = 32'(NUM_MODES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [MODE_W-1:0] mode_reg;
  logic [15:0]       word_reg;
  logic [15:0]       cmd_data_reg;
  logic [ADDR_W-1:0] index_reg;
  logic              error_reg;
  logic [7:0]        unit_cnt_reg;
  logic [CYC_W-1:0]  cyc_cnt_reg;

  logic is_end, is_delay, delay_zero, last_slot, cyc_zero, wait_done, mode_bad, step;

  // Register tables. Mode 1 (RGB565) differs from mode 0 (YUV422) only in
  // the COM7 and COM15 format slots. Reads past the sentinel return END_WORD.
  function automatic logic [15:0] rom_word(input logic [MODE_W-1:0] m,
                                           input logic [ADDR_W-1:0] a);
    logic [31:0] ai;
    logic        rgb;
    logic [15:0] w;
    ai  = 32'(a);
    rgb = (32'(m) == 32'd1);
    case (ai)
      32'd0:   w = 16'h1280;                       // COM7: soft reset
      32'd1:   w = {DELAY_REG, 8'h0A};             // let the sensor settle
      32'd2:   w = 16'h1280;                       // repeat reset after settling
      32'd3:   w = rgb ? 16'h1204 : 16'h1200;      // COM7: output format
      32'd4:   w = 16'h8C00;                       // RGB444 off
      32'd5:   w = rgb ? 16'h40D0 : 16'h40C0;      // COM15: range / RGB565
      32'd6:   w = 16'h1101;                       // CLKRC prescaler
      32'd7:   w = 16'h0C00;                       // COM3
      32'd8:   w = 16'h3E00;                       // COM14
      32'd9:   w = {DELAY_REG, 8'h00};             // zero delay: pure skip
      32'd10:  w = 16'h3A04;                       // TSLB
      default: w = END_WORD;
    endcase
    return w;
  endfunction

  assign is_end     = (word_reg == END_WORD);
  assign is_delay   = (word_reg[15:8] == DELAY_REG);
  assign delay_zero = (word_reg[7:0] == 8'h00);
  assign last_slot  = (index_reg == LAST_IDX);
  assign cyc_zero   = (cyc_cnt_reg == '0);
  assign wait_done  = cyc_zero && (unit_cnt_reg <= 8'd1);
  assign mode_bad   = (32'(mode) >= NUM_MODES_U);

  // An entry completes on a handshake, on delay expiry, or on a zero delay.
  assign step = ((state_reg == S_DECODE) && !is_end && is_delay && delay_zero) ||
                ((state_reg == S_SEND) && cmd.cmd_ready) ||
                ((state_reg == S_WAIT) && wait_done);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next state: start overrides everything, completing the last slot overruns.
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = S_FETCH;
    end else if (step) begin
      state_next = last_slot ? S_DONE : S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:  state_next = S_DECODE;
        S_DECODE: begin
          if (is_end)        state_next = S_DONE;
          else if (is_delay) state_next = S_WAIT;
          else               state_next = S_SEND;
        end
        default:  state_next = state_reg;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    cmd.cmd_valid = 1'b0;
    busy          = 1'b0;
    finished      = 1'b0;
    case (state_reg)
      S_IDLE:  ;
      S_DONE:  finished = 1'b1;
      S_SEND:  begin
        cmd.cmd_valid = 1'b1;
        busy          = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Registered table read; the word is only consumed in DECODE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_reg == S_FETCH) word_reg <= rom_word(mode_reg, index_reg);
  end

  // Datapath: mode latch, index, error flag, command word and delay counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg     <= '0;
      cmd_data_reg <= 16'h0000;
      index_reg    <= '0;
      error_reg    <= 1'b0;
      unit_cnt_reg <= 8'd0;
      cyc_cnt_reg  <= '0;
    end else if (start) begin
      // An out-of-range mode is flagged but the sequence still runs on table 0.
      mode_reg  <= mode_bad ? '0 : mode;
      error_reg <= mode_bad;
      index_reg <= '0;
    end else begin
      if (step) begin
        index_reg <= index_reg + 1'b1;
        if (last_slot) error_reg <= 1'b1;
      end
      case (state_reg)
        S_DECODE: begin
          if (!is_end) begin
            if (is_delay) begin
              unit_cnt_reg <= word_reg[7:0];
              cyc_cnt_reg  <= CYC_RELOAD;
            end else begin
              cmd_data_reg <= word_reg;
            end
          end
        end
        S_WAIT: begin
          if (!cyc_zero) begin
            cyc_cnt_reg <= cyc_cnt_reg - 1'b1;
          end else if (unit_cnt_reg > 8'd1) begin
            unit_cnt_reg <= unit_cnt_reg - 1'b1;
            cyc_cnt_reg  <= CYC_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd.cmd_data = cmd_data_reg;
  assign index        = index_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer: three instances (normal tables, 2-bit
// index for overrun, single mode for bad-mode handling), a command table of
// expected words and gaps, and a scoreboard popped on every handshake.
module tb_ov7670_cfg_sequencer;
  localparam int WU = 4;

  typedef struct {
    logic [15:0] cmd;    // expected command word
    int          idx;    // expected index while it is presented
    int          gap;    // cycles since previous handshake (or start) with ready high
    int          stall;  // cycles to hold cmd_ready low on this entry
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_s [3];
  logic        mode_s  [3];
  logic        ready_s [3];
  logic        valid_s [3];
  logic [15:0] data_s  [3];
  logic [7:0]  idx_s   [3];
  logic        busy_s  [3];
  logic        fin_s   [3];
  logic        err_s   [3];
  logic [7:0]  idx0, idx2;
  logic [1:0]  idx1;

  ov7670_cfg_sequencer_if bus0 (), bus1 (), bus2 ();

  assign bus0.cmd_ready = ready_s[0];
  assign bus1.cmd_ready = ready_s[1];
  assign bus2.cmd_ready = ready_s[2];
  assign valid_s[0] = bus0.cmd_valid;
  assign valid_s[1] = bus1.cmd_valid;
  assign valid_s[2] = bus2.cmd_valid;
  assign data_s[0]  = bus0.cmd_data;
  assign data_s[1]  = bus1.cmd_data;
  assign data_s[2]  = bus2.cmd_data;
  assign idx_s[0]   = idx0;
  assign idx_s[1]   = {6'd0, idx1};
  assign idx_s[2]   = idx2;

  ov7670_cfg_sequencer #(.ADDR_W(8), .NUM_MODES(2), .MODE_W(1), .WAIT_UNIT(WU)) u_main (
    .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]), .cmd(bus0),
    .index(idx0), .busy(busy_s[0]), .finished(fin_s[0]), .error(err_s[0]));

  ov7670_cfg_sequencer #(.ADDR_W(2), .NUM_MODES(2), .MODE_W(1), .WAIT_UNIT(WU)) u_ovr (
    .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]), .cmd(bus1),
    .index(idx1), .busy(busy_s[1]), .finished(fin_s[1]), .error(err_s[1]));

  ov7670_cfg_sequencer #(.ADDR_W(8), .NUM_MODES(1), .MODE_W(1), .WAIT_UNIT(WU)) u_one (
    .clk(clk), .rst(rst), .start(start_s[2]), .mode(mode_s[2]), .cmd(bus2),
    .index(idx2), .busy(busy_s[2]), .finished(fin_s[2]), .error(err_s[2]));

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_hs  = 0;
  int   hs_count = 0;
  int   act_dut  = -1;
  vec_t exp_q [$];
  vec_t tbl0 [9];
  vec_t tbl1 [9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Scoreboard: every handshake on any instance pops one expected entry.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst && valid_s[d] && ready_s[d]) begin
        $display("hs dut%0d cmd=%04h index=%0d cycle=%0d", d, data_s[d], idx_s[d], cyc);
        if (exp_q.size() == 0) begin
          chk("sb_pending", 32'(exp_q.size()), 32'd1);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          chk("hs_dut", d, act_dut);
          chk("cmd_data", 32'(data_s[d]), 32'(e.cmd));
          chk("hs_index", 32'(idx_s[d]), e.idx);
          chk("hs_gap", cyc - last_hs, e.gap);
          last_hs = cyc;
          hs_count++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d, input logic m);
    mode_s[d]  = m;
    start_s[d] = 1'b1;
    step();
    start_s[d] = 1'b0;
    last_hs    = cyc;
  endtask

  task automatic wait_hs(input int n);
    for (int k = 0; k < 600 && hs_count < n; k++) step();
    if (hs_count < n) chk("hs_timeout", hs_count, n);
  endtask

  task automatic wait_valid(input int d);
    for (int k = 0; k < 600 && !valid_s[d]; k++) step();
    if (!valid_s[d]) chk("valid_timeout", 32'(valid_s[d]), 32'd1);
  endtask

  task automatic wait_fin(input int d, input int gap);
    for (int k = 0; k < 600 && !fin_s[d]; k++) step();
    chk("finished", 32'(fin_s[d]), 32'd1);
    chk("finish_gap", cyc - last_hs, gap);
    chk("done_busy", 32'(busy_s[d]), 32'd0);
    chk("done_valid", 32'(valid_s[d]), 32'd0);
    chk("sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_seq(input int d, input logic m, input bit rgb, input bit stall_en, input int n);
    vec_t e;
    exp_q.delete();
    hs_count = 0;
    act_dut  = d;
    for (int i = 0; i < n; i++) begin
      if (rgb) e = tbl1[i];
      else     e = tbl0[i];
      if (stall_en) e.gap += e.stall;
      exp_q.push_back(e);
    end
    pulse_start(d, m);
    if (stall_en) begin
      for (int i = 0; i < n; i++) begin
        if (tbl0[i].stall > 0) begin
          wait_hs(i);
          ready_s[d] = 1'b0;
          wait_valid(d);
          for (int k = 0; k < tbl0[i].stall; k++) begin
            chk("stall_valid", 32'(valid_s[d]), 32'd1);
            chk("stall_data", 32'(data_s[d]), 32'(tbl0[i].cmd));
            chk("stall_index", 32'(idx_s[d]), tbl0[i].idx);
            step();
          end
          ready_s[d] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      mode_s[d]  = 1'b0;
      ready_s[d] = 1'b1;
    end
    // Mode 0 command stream: word, index, gap with ready high, stall cycles.
    tbl0[0] = '{16'h1280, 0,  2, 0};
    tbl0[1] = '{16'h1280, 2, 45, 0};  // after 10 x 4-cycle delay entry
    tbl0[2] = '{16'h1200, 3,  3, 7};
    tbl0[3] = '{16'h8C00, 4,  3, 0};
    tbl0[4] = '{16'h40C0, 5,  3, 0};
    tbl0[5] = '{16'h1101, 6,  3, 0};
    tbl0[6] = '{16'h0C00, 7,  3, 0};
    tbl0[7] = '{16'h3E00, 8,  3, 0};
    tbl0[8] = '{16'h3A04, 10, 5, 0};  // zero-delay entry skipped at index 9
    for (int i = 0; i < 9; i++) begin
      tbl1[i]       = tbl0[i];
      tbl1[i].stall = 0;
    end
    tbl1[2].cmd = 16'h1204;
    tbl1[4].cmd = 16'h40D0;

    // Reset and idle
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      for (int d = 0; d < 3; d++) chk("idle_valid", 32'(valid_s[d]), 32'd0);
    end
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", 32'(busy_s[d]), 32'd0);
      chk("rst_finished", 32'(fin_s[d]), 32'd0);
      chk("rst_error", 32'(err_s[d]), 32'd0);
      chk("rst_index", 32'(idx_s[d]), 32'd0);
      chk("rst_data", 32'(data_s[d]), 32'd0);
    end

    // Mode 0 with backpressure on the 1200 command
    run_seq(0, 1'b0, 1'b0, 1'b1, 9);
    wait_fin(0, 3);
    chk("m0_error", 32'(err_s[0]), 32'd0);
    chk("m0_end_index", 32'(idx_s[0]), 32'd11);

    // Mode 1
    run_seq(0, 1'b1, 1'b1, 1'b0, 9);
    wait_fin(0, 3);
    chk("m1_error", 32'(err_s[0]), 32'd0);

    // Restart while the index-5 command waits for ready
    exp_q.delete();
    hs_count = 0;
    act_dut  = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(tbl0[i]);
    pulse_start(0, 1'b0);
    wait_hs(4);
    ready_s[0] = 1'b0;
    wait_valid(0);
    chk("pre_restart_index", 32'(idx_s[0]), 32'd5);
    chk("pre_restart_data", 32'(data_s[0]), 32'h40C0);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(tbl0[i]);
    hs_count = 0;
    pulse_start(0, 1'b0);
    chk("restart_valid", 32'(valid_s[0]), 32'd0);
    chk("restart_index", 32'(idx_s[0]), 32'd0);
    chk("restart_busy", 32'(busy_s[0]), 32'd1);
    ready_s[0] = 1'b1;
    wait_fin(0, 3);

    // Overrun: 4-entry table with no sentinel
    run_seq(1, 1'b0, 1'b0, 1'b0, 3);
    wait_fin(1, 1);
    chk("ovr_error", 32'(err_s[1]), 32'd1);
    chk("ovr_index", 32'(idx_s[1]), 32'd0);

    // Out-of-range mode runs the mode 0 table with error set
    run_seq(2, 1'b1, 1'b0, 1'b0, 9);
    chk("bad_mode_error", 32'(err_s[2]), 32'd1);
    chk("bad_mode_busy", 32'(busy_s[2]), 32'd1);
    wait_fin(2, 3);
    chk("bad_mode_error_end", 32'(err_s[2]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
